// File: rtl/serial_tx.sv
// Frame-based serial transmitter: start bit, DW data bits LSB first, optional
// even-parity bit, stop bit, each held CLKS_PER_BIT clocks on an idle-high line.
module serial_tx #(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic          CK,
  input  logic          RN,
  input  logic [DW-1:0] D_IN,
  input  logic          D_VALID,
  output logic          D_READY,
  output logic          TXD,
  output logic          BUSY
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick;
  logic [BW-1:0]   bit_cnt;
  logic [DW-1:0]   shift;
  logic            par_bit;
  logic            txd_r;
  logic            busy_r;
  logic            ready_r;

  function automatic logic even_parity(input logic [DW-1:0] w);
    return ^w;
  endfunction

  // TXD is registered from the current state, so the line lags the FSM by
  // one clock: it falls on the edge after the one that accepted the word.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd_r <= 1'b1;
          if (D_VALID) begin
            shift   <= D_IN;
            par_bit <= even_parity(D_IN);
            tick    <= '0;
            bit_cnt <= '0;
            state   <= START;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end
        end
        START: begin
          txd_r <= 1'b0;
          if (tick == TICK_LAST) begin
            tick  <= '0;
            state <= DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          txd_r <= shift[0];
          if (tick == TICK_LAST) begin
            tick  <= '0;
            shift <= shift >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        PARITY: begin
          txd_r <= par_bit;
          if (tick == TICK_LAST) begin
            tick  <= '0;
            state <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          txd_r <= 1'b1;
          if (tick == TICK_LAST) begin
            tick    <= '0;
            state   <= IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          txd_r   <= 1'b1;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign TXD     = txd_r;
  assign BUSY    = busy_r;
  assign D_READY = ready_r;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (CPB=4 no parity, CPB=4 even parity,
// CPB=1 no parity) share one stimulus and are each checked against a frame model.
module tb_serial_tx;

  logic       CK;
  logic       RN;
  logic       D_VALID;
  logic [7:0] D_IN;
  wire  [2:0] txd;
  wire  [2:0] busy;
  wire  [2:0] ready;

  int n_tests = 0;
  int n_fail  = 0;

  serial_tx #(.DW(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
    .CK(CK), .RN(RN), .D_IN(D_IN), .D_VALID(D_VALID),
    .D_READY(ready[0]), .TXD(txd[0]), .BUSY(busy[0]));
  serial_tx #(.DW(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .CK(CK), .RN(RN), .D_IN(D_IN), .D_VALID(D_VALID),
    .D_READY(ready[1]), .TXD(txd[1]), .BUSY(busy[1]));
  serial_tx #(.DW(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
    .CK(CK), .RN(RN), .D_IN(D_IN), .D_VALID(D_VALID),
    .D_READY(ready[2]), .TXD(txd[2]), .BUSY(busy[2]));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: bit index 0 = start, 1..8 = data LSB first, optional parity, then stop.
  int cpb_a [3] = '{4, 4, 1};
  int par_a [3] = '{0, 1, 0};

  function automatic logic frame_bit(input logic [7:0] w, input int idx, input int p);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (p != 0 && idx == 9) return ^w;
    return 1'b1;
  endfunction

  int         m_act [3];
  int         m_cyc [3];
  logic [7:0] m_wrd [3];
  logic       e_txd [3];

  always @(posedge CK or negedge RN) begin
    for (int i = 0; i < 3; i++) begin
      if (!RN) begin
        m_act[i] = 0;
        m_cyc[i] = 0;
        m_wrd[i] = 8'h00;
        e_txd[i] = 1'b1;
      end else begin
        logic nx;
        int   len;
        len = (8 + par_a[i] + 2) * cpb_a[i];
        nx  = (m_act[i] != 0) ? frame_bit(m_wrd[i], m_cyc[i] / cpb_a[i], par_a[i]) : 1'b1;
        if (m_act[i] != 0) begin
          m_cyc[i]++;
          if (m_cyc[i] == len) m_act[i] = 0;
        end else if (D_VALID) begin
          m_act[i] = 1;
          m_cyc[i] = 0;
          m_wrd[i] = D_IN;
        end
        e_txd[i] = nx;
      end
    end
  end

  // Per-cycle compare, plus length of the most recent BUSY run per instance.
  int run_cnt [3];
  int last_run[3];

  always @(negedge CK) begin
    for (int i = 0; i < 3; i++) begin
      if (!RN) begin
        run_cnt[i] = 0;
      end else begin
        chk($sformatf("txd_u%0d", i),   32'(txd[i]),   32'(e_txd[i]));
        chk($sformatf("busy_u%0d", i),  32'(busy[i]),  32'(m_act[i] != 0));
        chk($sformatf("ready_u%0d", i), 32'(ready[i]), 32'(m_act[i] == 0));
        if (busy[i]) run_cnt[i]++;
        else if (run_cnt[i] > 0) begin
          last_run[i] = run_cnt[i];
          run_cnt[i]  = 0;
        end
      end
    end
  end

  logic [9:0]  rec0;
  logic [10:0] rec1;

  task automatic wait_idle();
    int n = 0;
    @(posedge CK); #1;
    while (ready !== 3'b111 && n < 200) begin
      @(posedge CK); #1;
      n++;
    end
    chk("idle_wait", 32'(ready), 32'h7);
  endtask

  // Launch one word and sample u0/u1 TXD in the middle of every bit time.
  task automatic send_rec(input logic [7:0] w);
    wait_idle();
    D_IN    = w;
    D_VALID = 1'b1;
    @(posedge CK); #1;
    D_VALID = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      @(posedge CK); #1;
      if ((k - 1) % 4 == 2) begin
        if ((k - 1) / 4 < 10) rec0[(k-1)/4] = txd[0];
        if ((k - 1) / 4 < 11) rec1[(k-1)/4] = txd[1];
      end
    end
  endtask

  task automatic count_ready_gap(input string name);
    int n = 0, hi = 0;
    bit seen = 0;
    while (n < 100 && !(seen && !ready[0])) begin
      @(posedge CK); #1;
      if (ready[0]) begin
        hi++;
        seen = 1;
      end
      n++;
    end
    chk(name, 32'(hi), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RN      = 1'b0;
    D_VALID = 1'b1;
    D_IN    = 8'h5A;
    rec0    = '0;
    rec1    = '0;

    // Reset held with clock running and D_VALID high.
    repeat (4) begin
      @(negedge CK);
      chk("rst_txd",   32'(txd),   32'h7);
      chk("rst_busy",  32'(busy),  32'h0);
      chk("rst_ready", 32'(ready), 32'h7);
    end
    @(posedge CK); #1;
    D_VALID = 1'b0;
    #1 RN = 1'b1;

    // 0xA5 framing and frame lengths.
    send_rec(8'hA5);
    chk("a5_bits_u0",  32'(rec0), 32'(10'b1101001010));
    chk("a5_bits_u1",  32'(rec1), 32'(11'b10101001010));
    chk("a5_busy_u0",  32'(last_run[0]), 32'd40);
    chk("a5_busy_u1",  32'(last_run[1]), 32'd44);
    chk("a5_busy_u2",  32'(last_run[2]), 32'd10);

    // Even parity.
    send_rec(8'h07);
    chk("par07", 32'(rec1[9]), 32'd1);
    chk("len07", 32'(last_run[1]), 32'd44);
    send_rec(8'h03);
    chk("par03", 32'(rec1[9]), 32'd0);

    // Back-to-back with D_VALID held high.
    wait_idle();
    D_IN    = 8'h11;
    D_VALID = 1'b1;
    @(posedge CK); #1;
    D_IN = 8'h22;
    count_ready_gap("b2b_ready_pulse");
    D_VALID = 1'b0;
    chk("b2b_run", 32'(last_run[0]), 32'd40);

    // D_IN changes mid-frame; the next word only after STOP.
    wait_idle();
    D_IN    = 8'h3C;
    D_VALID = 1'b1;
    @(posedge CK); #1;
    repeat (10) @(posedge CK);
    #1 D_IN = 8'hFF;
    count_ready_gap("midchg_ready_pulse");
    D_VALID = 1'b0;

    // Asynchronous reset during data bit 3 of u0.
    wait_idle();
    D_IN    = 8'hC3;
    D_VALID = 1'b1;
    @(posedge CK); #1;
    D_VALID = 1'b0;
    repeat (18) @(posedge CK);
    #2 chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    #1 RN = 1'b0;
    #1;
    chk("arst_txd",   32'(txd),   32'h7);
    chk("arst_busy",  32'(busy),  32'h0);
    chk("arst_ready", 32'(ready), 32'h7);
    repeat (2) @(posedge CK);
    #3 RN = 1'b1;
    send_rec(8'h81);
    chk("post_rst_bits", 32'(rec0), 32'(10'b1100000010));
    chk("post_rst_run",  32'(last_run[0]), 32'd40);

    repeat (5) @(posedge CK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
